// File: rtl/ieee80211_tx_ctrl.sv
// ieee80211_tx_ctrl: frame sequencer ahead of the 802.11 scrambler/encoder.
// Per frame: a config word, then one SIGNAL word (6 Mbps tag), then the
// upstream DATA words, then zero pad words up to a whole OFDM symbol.
//
// Handshakes (cfg, s_axis, m_axis): a transfer happens on a rising clock edge
// where valid && ready are both high. A valid source holds its payload stable
// until that edge. m_axis holds tdata/tuser/tlast stable while tvalid && !tready.
module ieee80211_tx_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      cfg_tdata,
  input  logic             cfg_tvalid,
  output logic             cfg_tready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       m_axis_tuser,
  output logic             busy,
  output logic             err,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SIGNAL = 3'd1,
    S_DATA   = 3'd2,
    S_PAD    = 3'd3,
    S_LAST   = 3'd4
  } state_t;

  localparam logic [3:0] RATE_6M = 4'b1101;

  state_t           r_state;
  logic [3:0]       r_rate;
  logic [11:0]      r_len;
  logic [15:0]      r_nwords;
  logic [15:0]      r_count;
  logic [7:0]       r_acc;
  logic [7:0]       r_ndbps;
  logic [WIDTH-1:0] r_tdata;
  logic [3:0]       r_tuser;
  logic             r_tlast;
  logic             r_tvalid;
  logic             r_err;
  logic             r_done;

  // Data bits per OFDM symbol for each rate code; 0 marks an invalid code.
  function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
    case (rate)
      4'b1101: rate_to_ndbps = 8'd24;
      4'b1111: rate_to_ndbps = 8'd36;
      4'b0101: rate_to_ndbps = 8'd48;
      4'b0111: rate_to_ndbps = 8'd72;
      4'b1001: rate_to_ndbps = 8'd96;
      4'b1011: rate_to_ndbps = 8'd144;
      4'b0001: rate_to_ndbps = 8'd192;
      4'b0011: rate_to_ndbps = 8'd216;
      default: rate_to_ndbps = 8'd0;
    endcase
  endfunction

  logic [7:0]       w_cfg_ndbps;
  logic             w_load;
  logic             w_s_hs;
  logic [8:0]       w_acc_sum;
  logic [8:0]       w_acc_diff;
  logic [7:0]       w_acc_next;
  logic [15:0]      w_count_next;
  logic             w_hit_n;
  logic             w_is_last;
  logic             w_data_err;
  logic [16:0]      w_sig_body;
  logic [WIDTH-1:0] w_sig;

  assign w_cfg_ndbps = rate_to_ndbps(cfg_tdata[3:0]);

  // Output register may take a new word when empty or being drained this edge.
  assign w_load = !r_tvalid || m_axis_tready;
  assign w_s_hs = s_axis_tvalid && s_axis_tready;

  // acc < N_DBPS and N_DBPS >= WIDTH, so one conditional subtract is the modulo.
  assign w_acc_sum  = {1'b0, r_acc} + 9'(WIDTH);
  assign w_acc_diff = w_acc_sum - {1'b0, r_ndbps};
  assign w_acc_next = (w_acc_sum >= {1'b0, r_ndbps}) ? w_acc_diff[7:0] : w_acc_sum[7:0];

  assign w_count_next = r_count + 16'd1;
  assign w_hit_n      = (w_count_next == r_nwords);
  assign w_is_last    = w_hit_n || s_axis_tlast;
  // Upstream framing disagreement: tlast early, or missing on the n_words-th word.
  assign w_data_err   = (s_axis_tlast && !w_hit_n) || (w_hit_n && !s_axis_tlast);

  // SIGNAL field: R1..R4 in bits 3:0 (rate[3] is R1), reserved bit 4, LENGTH, parity.
  assign w_sig_body = {r_len, 1'b0, r_rate[0], r_rate[1], r_rate[2], r_rate[3]};
  assign w_sig      = {{(WIDTH-18){1'b0}}, ^w_sig_body, w_sig_body};

  // Frame sequencer FSM together with the single-entry output register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_rate   <= '0;
      r_len    <= '0;
      r_nwords <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_ndbps  <= '0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_tvalid) begin
            r_rate   <= cfg_tdata[3:0];
            r_len    <= cfg_tdata[15:4];
            r_nwords <= cfg_tdata[31:16];
            r_ndbps  <= w_cfg_ndbps;
            r_count  <= '0;
            r_acc    <= '0;
            if (w_cfg_ndbps == 8'd0 || cfg_tdata[31:16] == 16'd0) r_err <= 1'b1;
            else                                                  r_state <= S_SIGNAL;
          end
        end
        S_SIGNAL: begin
          if (w_load) begin
            r_tdata  <= w_sig;
            r_tuser  <= RATE_6M;
            r_tlast  <= 1'b1;
            r_tvalid <= 1'b1;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_s_hs) begin
            r_tdata  <= s_axis_tdata;
            r_tuser  <= r_rate;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_count  <= w_count_next;
            r_acc    <= w_acc_next;
            if (w_is_last) begin
              r_err <= w_data_err;
              if (w_acc_next == 8'd0) begin
                r_tlast <= 1'b1;
                r_state <= S_LAST;
              end else begin
                r_state <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (w_load) begin
            r_tdata  <= '0;
            r_tuser  <= r_rate;
            r_tvalid <= 1'b1;
            r_acc    <= w_acc_next;
            r_tlast  <= (w_acc_next == 8'd0);
            if (w_acc_next == 8'd0) r_state <= S_LAST;
          end
        end
        S_LAST: begin
          if (r_tvalid && m_axis_tready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_tready    = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign s_axis_tready = (r_state == S_DATA) && w_load;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign err           = r_err;
  assign done          = r_done;

endmodule

// File: tb/tb_ieee80211_tx_ctrl.sv
// tb_ieee80211_tx_ctrl: directed frames from a vector table plus hand-written
// sequences for downstream stall with early tlast and reset during padding.
module tb_ieee80211_tx_ctrl;

  localparam int W = 24;

  logic          aclk;
  logic          areset;
  logic [31:0]   cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [3:0]    m_axis_tuser;
  logic          busy;
  logic          err;
  logic          done;

  ieee80211_tx_ctrl #(.WIDTH(W)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .busy(busy), .err(err), .done(done)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  bit busy_seen = 0;

  // Expected words: {tuser[3:0], tlast, tdata[23:0]}
  logic [28:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] dword(input int i);
    logic [23:0] t;
    t = i[23:0];
    case (i)
      0:       dword = 24'hAAAAAA;
      1:       dword = 24'h555555;
      default: dword = 24'h3C0000 ^ (t * 24'h010203);
    endcase
  endfunction

  // Scoreboard / monitor: samples mid-low-phase, after all drivers settle.
  bit          hold = 0;
  logic [28:0] prev_word;
  always @(negedge aclk) begin
    logic [28:0] cur;
    logic [28:0] e;
    #2;
    if (busy) busy_seen = 1;
    if (err)  err_cnt++;
    if (done) done_cnt++;
    if (!areset) begin
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (hold) begin
        check("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("hold_word", {3'd0, cur}, {3'd0, prev_word});
      end
      if (m_axis_tvalid && !m_axis_tready)
        check("s_ready_stall", {31'd0, s_axis_tready}, 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {3'd0, cur}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {3'd0, cur}, {3'd0, e});
        end
      end
      hold      = m_axis_tvalid && !m_axis_tready;
      prev_word = cur;
    end else begin
      hold = 0;
    end
  end

  // Driver tasks
  task automatic drive_cfg(input logic [3:0] rate, input logic [11:0] len, input logic [15:0] nw);
    @(negedge aclk);
    cfg_tdata  = {nw, len, rate};
    cfg_tvalid = 1'b1;
    #2;
    check("cfg_tready_idle", {31'd0, cfg_tready}, 32'd1);
    @(posedge aclk);
    #1;
    cfg_tvalid = 1'b0;
  endtask

  task automatic drive_words(input int n_send, input int tlast_pos);
    bit rdy;
    bit ok;
    for (int i = 0; i < n_send; i++) begin
      @(negedge aclk);
      s_axis_tdata  = dword(i);
      s_axis_tlast  = (tlast_pos == i + 1);
      s_axis_tvalid = 1'b1;
      ok = 0;
      for (int c = 0; c < 100; c++) begin
        #2;
        rdy = s_axis_tready;
        @(posedge aclk);
        if (rdy) begin
          ok = 1;
          break;
        end
        @(negedge aclk);
      end
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!ok) begin
        check("s_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic stall_proc(output bit stalled);
    stalled = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid && !m_axis_tlast) begin
        m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        m_axis_tready = 1'b1;
        stalled = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge aclk);
      #3;
      if (!busy) break;
    end
    check("frame_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge aclk);
  endtask

  task automatic push_frame(input logic [3:0] rate, input logic [23:0] sig, input int n_send,
                            input int n_pad);
    exp_q.push_back({4'b1101, 1'b1, sig});
    for (int i = 0; i < n_send; i++)
      exp_q.push_back({rate, (n_pad == 0) && (i == n_send - 1), dword(i)});
    for (int p = 0; p < n_pad; p++)
      exp_q.push_back({rate, p == n_pad - 1, 24'h000000});
  endtask

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input logic [15:0] nw,
                           input int tlast_pos, input int n_send, input logic [23:0] sig,
                           input int n_pad, input int n_err, input bit ok, input bit stall);
    bit stalled;
    err_cnt   = 0;
    done_cnt  = 0;
    busy_seen = 0;
    if (ok) push_frame(rate, sig, n_send, n_pad);
    drive_cfg(rate, len, nw);
    fork
      drive_words(n_send, tlast_pos);
      begin
        if (stall) stall_proc(stalled);
      end
    join
    wait_idle();
    if (stall) check("stall_applied", {31'd0, stalled}, 32'd1);
    check("exp_q_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    check("err_pulses", err_cnt, n_err);
    check("done_pulses", done_cnt, {31'd0, ok});
    if (!ok) begin
      check("busy_never", {31'd0, busy_seen}, 32'd0);
      check("cfg_tready_kept", {31'd0, cfg_tready}, 32'd1);
    end
  endtask

  typedef struct {
    logic [3:0]  rate;
    logic [11:0] len;
    logic [15:0] nw;
    int          tlast_pos;
    int          n_send;
    logic [23:0] sig;
    int          n_pad;
    int          n_err;
    bit          ok;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b1101, 12'd1,     16'd2, 2, 2, 24'h00002B, 0, 0, 1};
    vecs[1] = '{4'b1111, 12'd100,   16'd2, 2, 2, 24'h020C8F, 1, 0, 1};
    vecs[2] = '{4'b0011, 12'd10,    16'd5, 5, 5, 24'h00014C, 4, 0, 1};
    vecs[3] = '{4'b0000, 12'd5,     16'd2, 0, 0, 24'h000000, 0, 1, 0};
    vecs[4] = '{4'b1101, 12'd1,     16'd0, 0, 0, 24'h000000, 0, 1, 0};
    vecs[5] = '{4'b0101, 12'd3,     16'd3, 0, 3, 24'h00006A, 1, 1, 1};
    vecs[6] = '{4'b1001, 12'd7,     16'd6, 3, 3, 24'h0200E9, 1, 1, 1};
    vecs[7] = '{4'b0001, 12'hFFF,   16'd8, 8, 8, 24'h03FFE8, 0, 0, 1};
    vecs[8] = '{4'b1011, 12'd2,     16'd1, 1, 1, 24'h00004D, 5, 0, 1};
    vecs[9] = '{4'b0111, 12'd9,     16'd3, 3, 3, 24'h02012E, 0, 0, 1};

    areset        = 1'b1;
    cfg_tdata     = '0;
    cfg_tvalid    = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
    check("rst_tuser_tlast", {27'd0, m_axis_tuser, m_axis_tlast}, 32'd0);
    check("rst_flags", {28'd0, s_axis_tready, busy, err, done}, 32'd0);
    check("rst_cfg_tready", {31'd0, cfg_tready}, 32'd1);
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    for (int v = 0; v < 10; v++)
      run_frame(vecs[v].rate, vecs[v].len, vecs[v].nw, vecs[v].tlast_pos, vecs[v].n_send,
                vecs[v].sig, vecs[v].n_pad, vecs[v].n_err, vecs[v].ok, 1'b0);

    // Early tlast on word 2 of 4 with a 3-cycle downstream stall on the first DATA word.
    run_frame(4'b1101, 12'd4, 16'd4, 2, 2, 24'h00008B, 0, 1, 1'b1, 1'b1);

    // Reset while padding: outputs clear immediately, then a fresh frame works.
    err_cnt = 0;
    push_frame(4'b0011, 24'h00014C, 5, 4);
    drive_cfg(4'b0011, 12'd10, 16'd5);
    drive_words(5, 5);
    @(negedge aclk);
    #4;
    check("pads_pending", exp_q.size(), 32'd4);
    check("busy_in_pad", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("arst_tdata", {8'd0, m_axis_tdata}, 32'd0);
    check("arst_tuser_tlast", {27'd0, m_axis_tuser, m_axis_tlast}, 32'd0);
    check("arst_flags", {28'd0, s_axis_tready, busy, err, done}, 32'd0);
    check("arst_cfg_tready", {31'd0, cfg_tready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    run_frame(4'b1101, 12'd1, 16'd1, 1, 1, 24'h00002B, 0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ieee80211_tx_ctrl.md
Name: ieee80211_tx_ctrl

Overview:
Frame sequencer placed in front of the 802.11 transmit chain (scrambler → convolutional encoder). It accepts a per-frame config word and emits a 24-bit SIGNAL word tagged with the 6 Mbps rate. It then passes the packed DATA-field words from upstream, appending zero pad words until the DATA bit count is a whole number of OFDM symbols. tuser carries the rate code and tlast delimits the SIGNAL packet and the DATA packet.

Parameters:
WIDTH, 24, data word width in bits; must be 24 because the SIGNAL field is exactly one word.

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
cfg_tdata  in  32  [3:0] rate {R1,R2,R3,R4}, [15:4] LENGTH (bytes), [31:16] n_words (DATA words from upstream)
cfg_tvalid  in  1  config valid
cfg_tready  out  1  config accept; high only in IDLE
s_axis_tdata  in  WIDTH  packed DATA-field word (SERVICE+PSDU+tail)
s_axis_tvalid  in  1  upstream valid
s_axis_tready  out  1  upstream ready
s_axis_tlast  in  1  upstream last word of frame
m_axis_tdata  out  WIDTH  to chain
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  end of SIGNAL packet / end of DATA packet
m_axis_tuser  out  4  rate code for current word
busy  out  1  state != IDLE
err  out  1  one-cycle error pulse
done  out  1  one-cycle pulse when the final DATA/pad word handshakes

Behaviour:
- Reset (async, immediate): state=IDLE; m_axis_tvalid/tdata/tlast/tuser=0; s_axis_tready=0; busy=0; err=0; done=0; cfg_tready=1. All counters are cleared. Reset mid-frame abandons the frame; the next frame starts fresh after release.
- Output stage: a single register. It loads when !m_axis_tvalid || m_axis_tready and holds tdata/tuser/tlast stable while tvalid && !tready.
- Rate → N_DBPS: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216. Any other code is invalid.
- IDLE: on a cfg handshake, latch rate, LENGTH and n_words.
  - Invalid rate or n_words==0: pulse err, remain in IDLE, emit nothing.
  - Otherwise: go to SIGNAL.
- SIGNAL: load one word: bit0=R1, bit1=R2, bit2=R3, bit3=R4, bit4=0, bits16:5=LENGTH (LSB at bit5), bit17=even parity over bits16:0, bits23:18=0. tuser=4'b1101, tlast=1. After its handshake go to DATA.
- DATA:
  - s_axis_tready = output stage can load. Each accepted word is copied with tuser=rate, 1-cycle latency.
  - Track word count and acc = (acc+WIDTH) mod N_DBPS, initialised to 0.
  - Last data word is reached when count==n_words OR s_axis_tlast=1.
  - Early s_axis_tlast (count<n_words): pulse err, treat as last.
  - n_words-th word without s_axis_tlast: pulse err, treat as last; the upstream remainder is not consumed.
  - On last data word: if acc(after)==0, set tlast=1 on that word and return to IDLE after its handshake, pulsing done. Otherwise go to PAD with tlast=0.
- PAD: s_axis_tready=0. Emit zero words with tuser=rate, advancing acc. The word that brings acc to 0 carries tlast=1; after its handshake pulse done and go to IDLE. Termination is guaranteed because 24·k mod N_DBPS returns to 0.
- cfg_tready=0 outside IDLE; cfg is ignored while busy.
- Simultaneous err and tlast/done in the same cycle is allowed.

Test Plan:
- cfg rate=1101, LENGTH=1, n_words=2; upstream D0=0xAAAAAA, D1=0x555555 (tlast on D1); tready=1 → SIGNAL 0x00002B tuser 1101 tlast=1, then D0, D1(tlast=1), tuser 1101, no pad, done pulse, err=0.
- rate=1111, LENGTH=100, n_words=2 → SIGNAL 0x020C8F (parity=1), D0, D1(tlast=0), one pad word 0x000000 tlast=1, tuser 1111.
- rate=0011, n_words=5 → SIGNAL, 5 data words, 4 zero pad words, tlast only on the 4th pad word (9 words = 216 bits).
- rate=0000 → cfg accepted, err high exactly 1 cycle, no m_axis_tvalid, busy stays 0, cfg_tready stays 1.
- rate=1101, n_words=4, s_axis_tlast on word 2 → err pulse, 2 data words, tlast on word 2; m_axis_tready held low 3 cycles mid-DATA → tdata stable, s_axis_tready=0.
- areset asserted during PAD → all outputs 0 within the same cycle (async), cfg_tready=1; next frame (rate=1101, n_words=1) → correct SIGNAL and DATA words.
